// File: rtl/util_pkg.sv
// util_pkg: shared fetch-path types and sizing constants
// INSTR_COUNT   packets per fetch group and per decode group
// PACKET_SIZE   bits per fetched packet
// FQ_DEPTH      default fetch packet queue depth
// fetched_packet {pc[31:0], data[31:0], taken_branch}
package util_pkg;
    localparam int INSTR_COUNT = 2;
    localparam int PACKET_SIZE = 65;
    localparam int FQ_DEPTH = 8;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        taken_branch;
    } fetched_packet;
endpackage

// File: rtl/fetch_packet_queue.sv
// fetch_packet_queue: circular packet FIFO between instruction fetch and decode
// clk           rising-edge clock
// rst_n         asynchronous active-low reset
// valid_i       IF presents a fetch group
// valid_mask_i  per-slot valid of the fetch group
// packet_i      fetch group, slot 0 oldest
// ready_o       room for a full fetch group
// flush_i       discard all queued packets
// valid_o       per-slot valid toward decode, contiguous from slot 0
// packet_o      oldest entries, zero in invalid slots
// ready_i       decode accepts every valid slot
// occupancy_o   current entry count
module fetch_packet_queue
    import util_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   valid_i,
    input  logic [INSTR_COUNT-1:0]                 valid_mask_i,
    input  fetched_packet [INSTR_COUNT-1:0]        packet_i,
    output logic                                   ready_o,
    input  logic                                   flush_i,
    output logic [INSTR_COUNT-1:0]                 valid_o,
    output fetched_packet [INSTR_COUNT-1:0]        packet_o,
    input  logic                                   ready_i,
    output logic [$clog2(DEPTH):0]                 occupancy_o
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0] cnt_t;

    ptr_t head, tail;
    cnt_t count, pushed, popped;
    logic push, pop;
    fetched_packet mem [DEPTH];

    function automatic cnt_t popcount(input logic [INSTR_COUNT-1:0] m);
        cnt_t n;
        n = '0;
        for (int i = 0; i < INSTR_COUNT; i++) n = n + cnt_t'(m[i]);
        return n;
    endfunction

    // Compaction: a set slot lands after every set slot below it.
    function automatic ptr_t slot_offset(input logic [INSTR_COUNT-1:0] m, input int k);
        ptr_t n;
        n = '0;
        for (int i = 0; i < INSTR_COUNT; i++) if (i < k) n = n + ptr_t'(m[i]);
        return n;
    endfunction

    always_comb begin
        ready_o = count <= cnt_t'(DEPTH - INSTR_COUNT);
        valid_o = '0;
        packet_o = '0;
        for (int k = 0; k < INSTR_COUNT; k++) begin
            valid_o[k] = count > cnt_t'(k);
            packet_o[k] = valid_o[k] ? mem[head + ptr_t'(k)] : '0;
        end
    end

    assign push = valid_i & ready_o & ~flush_i;
    assign pop = ready_i & ~flush_i;
    assign pushed = push ? popcount(valid_mask_i) : '0;
    assign popped = pop ? popcount(valid_o) : '0;
    assign occupancy_o = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            head <= head + ptr_t'(popped);
            tail <= tail + ptr_t'(pushed);
            count <= count + pushed - popped;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            for (int k = 0; k < INSTR_COUNT; k++)
                if (valid_mask_i[k]) mem[tail + slot_offset(valid_mask_i, k)] <= packet_i[k];
    end
endmodule

// File: tb/tb_fetch_packet_queue.sv
// tb_fetch_packet_queue: directed bench with a queue-based reference model
module tb_fetch_packet_queue;
    import util_pkg::*;
    localparam int DEPTH = FQ_DEPTH;

    logic clk = 0;
    logic rst_n = 0;
    logic valid_i = 0;
    logic [INSTR_COUNT-1:0] valid_mask_i = '0;
    fetched_packet [INSTR_COUNT-1:0] packet_i = '0;
    logic ready_o;
    logic flush_i = 0;
    logic [INSTR_COUNT-1:0] valid_o;
    fetched_packet [INSTR_COUNT-1:0] packet_o;
    logic ready_i = 0;
    logic [$clog2(DEPTH):0] occupancy_o;

    int errors = 0;
    int checks = 0;
    fetched_packet q[$];
    logic [31:0] got[$];
    logic [31:0] want[$];
    bit collect = 0;

    fetch_packet_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .valid_mask_i(valid_mask_i),
        .packet_i(packet_i), .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o),
        .packet_o(packet_o), .ready_i(ready_i), .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic fetched_packet mk(input logic [31:0] pc);
        fetched_packet p;
        p.pc = pc;
        p.data = ~pc ^ 32'h5a5a_0000;
        p.taken_branch = pc[2];
        return p;
    endfunction

    // Reference model: a plain queue of packets, oldest at the front.
    int mn;
    bit mrdy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush_i) q.delete();
        else begin
            mn = q.size();
            mrdy = (DEPTH - mn) >= INSTR_COUNT;
            if (ready_i) repeat (mn < INSTR_COUNT ? mn : INSTR_COUNT) void'(q.pop_front());
            if (valid_i && mrdy)
                for (int k = 0; k < INSTR_COUNT; k++) if (valid_mask_i[k]) q.push_back(packet_i[k]);
        end
    end

    always @(posedge clk)
        if (collect && rst_n && ready_i && !flush_i)
            for (int k = 0; k < INSTR_COUNT; k++) if (valid_o[k]) got.push_back(packet_o[k].pc);

    logic [INSTR_COUNT-1:0] ev;
    fetched_packet [INSTR_COUNT-1:0] ep;
    always @(negedge clk) begin
        for (int k = 0; k < INSTR_COUNT; k++) begin
            ev[k] = q.size() > k;
            ep[k] = ev[k] ? q[k] : '0;
        end
        chk("valid_o", valid_o, ev);
        chk("packet_o", packet_o, ep);
        chk("occupancy_o", occupancy_o, q.size());
        chk("ready_o", ready_o, (DEPTH - q.size()) >= INSTR_COUNT);
    end

    task automatic step(input bit v, input logic [1:0] m, input fetched_packet p0,
                        input fetched_packet p1, input bit r, input bit f);
        valid_i = v;
        valid_mask_i = m;
        packet_i[0] = p0;
        packet_i[1] = p1;
        ready_i = r;
        flush_i = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 2'b00);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_packet", packet_o, 0);
        rst_n = 1;
        step(0, 2'b00, '0, '0, 0, 0);
        chk("idle_valid", valid_o, 2'b00);
        chk("idle_ready", ready_o, 1'b1);

        step(1, 2'b11, mk(32'h100), mk(32'h104), 0, 0);
        chk("push_valid", valid_o, 2'b11);
        chk("push_pc0", packet_o[0].pc, 32'h100);
        chk("push_pc1", packet_o[1].pc, 32'h104);
        chk("push_occ", occupancy_o, 2);
        step(0, 2'b00, '0, '0, 1, 0);
        chk("pop_occ", occupancy_o, 0);

        step(1, 2'b10, mk(32'hdead), mk(32'h20c), 0, 0);
        step(1, 2'b01, mk(32'h210), mk(32'hbeef), 0, 0);
        chk("mask_pc0", packet_o[0].pc, 32'h20c);
        chk("mask_pc1", packet_o[1].pc, 32'h210);
        chk("mask_occ", occupancy_o, 2);
        step(0, 2'b00, '0, '0, 1, 0);

        for (int i = 0; i < 3; i++) step(1, 2'b11, mk(32'h500 + 8 * i), mk(32'h504 + 8 * i), 0, 0);
        step(1, 2'b01, mk(32'h518), mk(32'h0), 0, 0);
        chk("full_occ", occupancy_o, 7);
        chk("full_ready", ready_o, 1'b0);
        step(1, 2'b11, mk(32'h600), mk(32'h604), 0, 0);
        chk("reject_occ", occupancy_o, 7);
        chk("reject_pc0", packet_o[0].pc, 32'h500);
        step(0, 2'b00, '0, '0, 1, 0);
        chk("drain_occ", occupancy_o, 5);
        chk("drain_ready", ready_o, 1'b1);
        repeat (3) step(0, 2'b00, '0, '0, 1, 0);
        chk("empty_occ", occupancy_o, 0);

        got.delete();
        want.delete();
        collect = 1;
        for (int i = 0; i < 20; i++) begin
            want.push_back(32'h1000 + 8 * i);
            want.push_back(32'h1004 + 8 * i);
            step(1, 2'b11, mk(32'h1000 + 8 * i), mk(32'h1004 + 8 * i), 1, 0);
        end
        repeat (2) step(0, 2'b00, '0, '0, 1, 0);
        collect = 0;
        chk("wrap_count", got.size(), 40);
        for (int i = 0; i < 40; i++) chk($sformatf("wrap_pc%0d", i), i < got.size() ? got[i] : 32'hx, want[i]);

        step(1, 2'b11, mk(32'h700), mk(32'h704), 0, 0);
        step(1, 2'b11, mk(32'h708), mk(32'h70c), 0, 0);
        step(1, 2'b01, mk(32'h710), mk(32'h0), 0, 0);
        chk("preflush_occ", occupancy_o, 5);
        step(1, 2'b11, mk(32'h720), mk(32'h724), 1, 1);
        chk("flush_occ", occupancy_o, 0);
        chk("flush_valid", valid_o, 2'b00);
        chk("flush_ready", ready_o, 1'b1);
        step(1, 2'b11, mk(32'h300), mk(32'h304), 0, 0);
        chk("postflush_valid", valid_o, 2'b11);
        chk("postflush_pc0", packet_o[0].pc, 32'h300);

        step(1, 2'b11, mk(32'h308), mk(32'h30c), 0, 0);
        valid_i = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_occ", occupancy_o, 0);
        chk("arst_valid", valid_o, 2'b00);
        chk("arst_packet", packet_o, 0);
        chk("arst_ready", ready_o, 1'b1);
        @(posedge clk);
        #1 rst_n = 1;
        step(1, 2'b11, mk(32'h400), mk(32'h404), 0, 0);
        chk("rearm_pc0", packet_o[0].pc, 32'h400);
        chk("rearm_occ", occupancy_o, 2);
        step(0, 2'b00, '0, '0, 0, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_packet_queue.md
# fetch_packet_queue

Receive-side buffer between instruction fetch and decode. Accepts up to INSTR_COUNT fetched packets per cycle from the IF stage through a valid/ready handshake and stores them in a circular FIFO. Presents the oldest INSTR_COUNT entries to decode, retires them when decode accepts, and discards all contents on a pipeline flush.

## Interface
- DEPTH, 8, number of packet entries; power of two, ≥ 2*INSTR_COUNT
- INSTR_COUNT, 2, packets per fetch group and per decode group
- PACKET_SIZE, 65, bits per packet: pc[31:0], data[31:0], taken_branch

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_i  in  1  IF presents a fetch group this cycle
- valid_mask_i  in  INSTR_COUNT  per-slot valid of the fetch group; any non-zero pattern is legal
- packet_i  in  INSTR_COUNT*PACKET_SIZE  fetch group; slot 0 is the oldest, at LSBs
- ready_o  out  1  queue can accept a full fetch group
- flush_i  in  1  discard all queued packets
- valid_o  out  INSTR_COUNT  per-slot valid toward decode; always contiguous from slot 0
- packet_o  out  INSTR_COUNT*PACKET_SIZE  oldest entries; slot 0 is the oldest
- ready_i  in  1  decode accepts every slot with valid_o=1 this cycle
- occupancy_o  out  $clog2(DEPTH)+1  current entry count

## Operation
- State: head and tail pointers, each $clog2(DEPTH) bits, wrap modulo DEPTH; count, $clog2(DEPTH)+1 bits; entry storage, not reset.
- ready_o = (DEPTH − count) ≥ INSTR_COUNT, from the registered count only.
- Push when valid_i & ready_o & ~flush_i:
  - Slots with mask bit set are written in slot order (compacted) at tail, tail+1, …
  - tail and count advance by popcount(valid_mask_i).
  - Example: mask 2'b10 writes only slot 1, at tail.
- valid_i while ready_o=0: group is not accepted and no state changes. IF holds the group.
- Output: valid_o[k] = (count > k). packet_o slot k = entry[head+k], or all-zero when valid_o[k]=0.
- Pop when ready_i & ~flush_i: head advances and count decreases by popcount(valid_o).
- Simultaneous push and pop: count_next = count + pushed − popped. Acceptance uses pre-pop count, so it is conservative.
- flush_i has highest priority. head, tail and count go to 0, and any same-cycle push or pop is ignored.
- Reset: head=tail=count=0, valid_o=0, packet_o=0, occupancy_o=0, ready_o=1.

## Timing
- Enqueue to output latency is 1 cycle. A packet written at edge N appears on packet_o after edge N. There is no bypass.
- ready_o, valid_o and packet_o are driven from registered state plus storage reads only. No combinational path exists from valid_i or ready_i to any output.
- Flush asserted in cycle N: valid_o=0 and occupancy_o=0 from edge N onward. ready_o=1 in cycle N+1.
- Full boundary: count = DEPTH−INSTR_COUNT+1 … DEPTH gives ready_o=0, even if decode pops in the same cycle.
- Empty boundary: count=0 gives valid_o all 0, and ready_i has no effect.
- Wrap: pointer increments crossing DEPTH−1 wrap to 0 without a gap.
- rst_n assertion mid-operation clears all state immediately, asynchronously. Outputs take reset values while rst_n=0.

## Structure
- The fetched_packet typedef, INSTR_COUNT, PACKET_SIZE and a new FQ_DEPTH constant (=8) live in the shared util_pkg. Ports use fetched_packet[INSTR_COUNT-1:0] where the tool allows.
- No sub-module. Storage is a register array inside the block; the compaction logic and the popcount are local functions.

## Test plan
- Reset, then idle → valid_o=2'b00, ready_o=1, occupancy_o=0, packet_o=0.
- Push group {pc 0x100, pc 0x104}, mask 2'b11, ready_i=0 → next cycle valid_o=2'b11, packet_o slot0.pc=0x100, slot1.pc=0x104, occupancy_o=2.
- Push mask 2'b10 with slot1.pc=0x20C, then mask 2'b01 with slot0.pc=0x210 → entries in order 0x20C, 0x210 and occupancy_o=2.
- Fill to 7 entries with ready_i=0 → ready_o=0. A pushed group is not accepted while ready_o=0 and occupancy stays at 7. Pop 2 → ready_o=1.
- Run 20 pushes of 2 packets and 20 pops so the pointers wrap ≥ 4 times → output PC sequence matches input order exactly, with no loss or duplication.
- flush_i in the same cycle as push and pop, with 5 entries queued → next cycle occupancy_o=0 and valid_o=0. Pushing resumes normally in the following cycle.
